// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined
// Single-port on-chip RAM behind an Avalon-MM slave. It provides a 1- or
// 2-cycle read pipeline with readdatavalid, and waitrequest back-pressure
// while a hardware clear sweep zeroes the array. The array is swept after
// reset (optional) or on a clear_req pulse.

module onchip_memory_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic                      clken,
    input  logic                      clear_req,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic                      clear_busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   clear_cnt_r;
    logic [ADDR_WIDTH-1:0]   clear_cnt_next_s;
    logic                    clear_we_s;

    logic                    xfer_s;
    logic                    wr_acc_s;
    logic                    rd_acc_s;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    rd_v1_r;
    logic [DATA_WIDTH-1:0]   rd_d1_r;
    logic                    last_v_s;
    logic [DATA_WIDTH-1:0]   last_d_s;

    // Busy flags come straight from the state register so they are glitch-free.
    assign waitrequest = (state_r == ST_CLEAR);
    assign clear_busy  = (state_r == ST_CLEAR);

    // Clear FSM next state: a sweep writes one word per cycle and ignores clken.
    always_comb begin
        state_next_s     = state_r;
        clear_cnt_next_s = clear_cnt_r;
        clear_we_s       = 1'b0;
        case (state_r)
            ST_READY: begin
                clear_cnt_next_s = ZERO_ADDR;
                if (clear_req) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_CLEAR: begin
                clear_we_s       = 1'b1;
                // Counter wraps to zero naturally after the last word.
                clear_cnt_next_s = clear_cnt_r + ONE_ADDR;
                if (clear_cnt_r == LAST_ADDR) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: begin
                state_next_s     = ST_READY;
                clear_cnt_next_s = ZERO_ADDR;
            end
        endcase
    end

    // Clear FSM state and sweep counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RESET_STATE;
            clear_cnt_r <= ZERO_ADDR;
        end else begin
            state_r     <= state_next_s;
            clear_cnt_r <= clear_cnt_next_s;
        end
    end

    // Transfer acceptance; a write beats a simultaneous read.
    always_comb begin
        xfer_s   = 1'b0;
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (chipselect && (read || write) && !waitrequest && clken) begin
            xfer_s   = 1'b1;
            wr_acc_s = write;
            rd_acc_s = read & ~write;
        end else begin
            xfer_s   = 1'b0;
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
    end

    // RAM write port: the clear sweep owns the port while busy, otherwise byte-masked writes.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[clear_cnt_r] <= ZERO_WORD;
        end else if (wr_acc_s) begin
            mem_r[address] <= merge_bytes(mem_r[address], writedata, byteenable);
        end
    end

    // First read stage: sample the addressed word at the accept edge; frozen while clken is low.
    // Capturing the data here means a clear starting right after still returns pre-clear data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v1_r <= 1'b0;
            rd_d1_r <= ZERO_WORD;
        end else if (clken) begin
            rd_v1_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_d1_r <= mem_r[address];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2_r;
            logic [DATA_WIDTH-1:0] rd_d2_r;

            // Extra output register stage, also frozen while clken is low.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_v2_r <= 1'b0;
                    rd_d2_r <= ZERO_WORD;
                end else if (clken) begin
                    rd_v2_r <= rd_v1_r;
                    if (rd_v1_r) begin
                        rd_d2_r <= rd_d1_r;
                    end
                end
            end

            assign last_v_s = rd_v2_r;
            assign last_d_s = rd_d2_r;
        end else begin : g_lat1
            assign last_v_s = rd_v1_r;
            assign last_d_s = rd_d1_r;
        end
    endgenerate

    // Gating with clken keeps a frozen response from being presented more than once.
    assign readdata      = last_d_s;
    assign readdatavalid = last_v_s & clken;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Scoreboard bench for onchip_memory_pipelined (32-bit words, 16 deep, read latency 2).
// A reference model tracks memory contents, clear busy time and expected
// read responses; a negedge monitor compares DUT outputs against it.

module tb_onchip_memory_pipelined;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 2;

    logic          clk;
    logic          reset;
    logic [AW-1:0] address;
    logic [BW-1:0] byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;
    logic          clear_req;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          clear_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        int            stamp;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left = 0;
    int            en_cnt    = 0;

    onchip_memory_pipelined #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .clear_req     (clear_req),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .clear_busy    (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: a transfer is taken when the slave is not busy and clken is high.
    // A clear sweep keeps the slave busy for DEPTH cycles and leaves every word zero.
    always @(posedge clk) begin : model_p
        logic acc;
        if (reset) begin
            exp_q.delete();
            busy_left = DEPTH;
            en_cnt    = 0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else begin
            if (clken) en_cnt++;
            acc = chipselect && (read || write) && (busy_left == 0) && clken;
            if (acc && write) begin
                for (int i = 0; i < BW; i++)
                    if (byteenable[i]) mem_m[address][i*8 +: 8] = writedata[i*8 +: 8];
            end else if (acc && read) begin
                exp_q.push_back('{data: mem_m[address], addr: address, stamp: en_cnt});
            end
            if (busy_left > 0) begin
                busy_left--;
            end else if (clear_req) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            end
        end
    end

    // Monitor: busy flags every cycle, stall gating, and in-order read responses.
    always @(negedge clk) begin : monitor_p
        exp_t e;
        if (!reset) begin
            check("waitrequest", {31'd0, waitrequest}, {31'd0, busy_left != 0});
            check("clear_busy", {31'd0, clear_busy}, {31'd0, busy_left != 0});
            if (clken === 1'b0) check("rdv_during_stall", {31'd0, readdatavalid}, 32'd0);
            if (readdatavalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdv", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rd_data@%0d", e.addr), readdata, e.data);
                    check("rd_latency", 32'(en_cnt), 32'(e.stamp + LAT - 1));
                end
            end
        end
    end

    task automatic drive(input logic c, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be, input logic ce,
                         input logic clr);
        @(posedge clk);
        #1;
        chipselect = c; read = r; write = w; address = a;
        writedata = d; byteenable = be; clken = ce; clear_req = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        drive(1'b1, 1'b0, 1'b1, a, d, be, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b1, 1'b1, 1'b0, a, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0;
        writedata = '0; byteenable = '0; clken = 1'b1; clear_req = 1'b0;
        #1;
        check("rst_readdatavalid", {31'd0, readdatavalid}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0;
        writedata = '0; byteenable = '0; clken = 1'b1; clear_req = 1'b0;
        #1;
        reset_dut();

        // Power-up sweep, then every word reads zero.
        idle(DEPTH + 4);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        idle(4);

        // Byte-lane merge, read immediately after the write.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3);
        wr(4'd4, 32'hDEADBEEF, 4'b0000);
        rd(4'd4);
        idle(4);

        // Back-to-back pipelined reads of freshly written words.
        for (int a = 0; a < 8; a++) wr(AW'(a), $urandom, 4'b1111);
        for (int a = 0; a < 8; a++) rd(AW'(a));
        idle(4);

        // clken stalls with the response in stage 1, then in stage 2; accesses during stalls are dropped.
        rd(4'd2);
        repeat (3) drive(1'b1, 1'b0, 1'b1, 4'd2, 32'h0BAD0BAD, 4'b1111, 1'b0, 1'b0);
        idle(4);
        rd(4'd6);
        idle(1);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 4'd5, '0, '0, 1'b0, 1'b0);
        idle(4);
        rd(4'd2);
        idle(4);

        // Clear request, a second request mid-sweep, and a write attempt during the sweep.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'hFFFFFFFF, 4'b1111);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(4);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        idle(2);
        wr(4'd7, 32'h12345678, 4'b1111);
        idle(DEPTH);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));
        idle(4);

        // Reset at sweep word 5 with two reads frozen in the pipeline.
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom, 4'b1111);
        rd(4'd1);
        rd(4'd9);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        reset_dut();
        idle(DEPTH + 4);
        rd(4'd1);
        rd(4'd9);
        rd(4'd15);
        idle(4);

        // Random traffic with random stalls and occasional clears.
        for (int n = 0; n < 500; n++) begin
            int op;
            op = $urandom_range(0, 9);
            drive((op != 8), (op <= 3) || (op == 9), (op >= 4) && (op != 8),
                  AW'($urandom), $urandom, BW'($urandom), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 99) == 0));
        end
        idle(DEPTH + 6);

        check("responses_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
